// File: rtl/rs_dec_rd_engine_pkg.sv
// Shared types for the Reed-Solomon decoder read path: block type, read-engine
// states and cache-line helpers.
package rs_dec_rd_engine_pkg;

  typedef logic [511:0] t_block;

  typedef enum logic [1:0] {
    S_RE_IDLE,
    S_RE_FETCH,
    S_RE_DRAIN,
    S_RE_FINISH
  } t_rd_eng_state;

  localparam int unsigned CL_BYTES = 64;
  localparam int unsigned CL_SHIFT = $clog2(CL_BYTES);

  // Number of cache lines covering a byte count, rounded up.
  function automatic logic [26:0] line_count(input logic [31:0] size);
    logic [31:0] lines;
    logic        partial;
    lines   = size >> CL_SHIFT;
    partial = (size & 32'(CL_BYTES - 1)) != 32'd0;
    return 27'(lines) + 27'(partial);
  endfunction

endpackage

// File: rtl/rs_dec_rob.sv
// Reorder buffer: one 512-bit line per slot, written by response tag and read
// in order at the head slot.
module rs_dec_rob
  import rs_dec_rd_engine_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned IdxW  = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            alloc_i,
  input  logic [IdxW-1:0] alloc_idx_i,
  input  logic            wr_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  t_block          wr_data_i,
  input  logic            pop_i,
  input  logic [IdxW-1:0] head_idx_i,
  output logic            tag_pending_o,
  output logic            head_valid_o,
  output t_block          head_data_o
);

  t_block           mem_q [Depth];
  logic [Depth-1:0] pending_q, pending_d;
  logic [Depth-1:0] valid_q, valid_d;

  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    pending_d = pending_q;
    valid_d   = valid_q;
    if (alloc_i) begin
      pending_d[alloc_idx_i] = 1'b1;
    end
    if (wr_i) begin
      pending_d[wr_idx_i] = 1'b0;
      valid_d[wr_idx_i]   = 1'b1;
    end
    if (pop_i) begin
      valid_d[head_idx_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      valid_q   <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
    end
  end

  assign tag_pending_o = pending_q[wr_idx_i];
  assign head_valid_o  = valid_q[head_idx_i];
  // Zero when empty so the block bus is quiet after reset.
  assign head_data_o   = head_valid_o ? mem_q[head_idx_i] : '0;

endmodule

// File: rtl/rs_dec_rd_engine.sv
// Read-fetch stage: turns a host buffer into CCI-P c0 line reads and delivers
// the returned lines in address order to the decoder core.
module rs_dec_rd_engine
  import rs_dec_rd_engine_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CL_ADDR_W       = 42,
  parameter int unsigned MDATA_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [63:0]          buf_addr,
  input  logic [31:0]          buf_size,
  input  logic                 c0_alm_full,
  output logic                 rd_req_valid,
  output logic [CL_ADDR_W-1:0] rd_req_addr,
  output logic [MDATA_W-1:0]   rd_req_mdata,
  input  logic                 rd_rsp_valid,
  input  logic [MDATA_W-1:0]   rd_rsp_mdata,
  input  logic [511:0]         rd_rsp_data,
  output logic                 blk_valid,
  output logic [511:0]         blk_data,
  input  logic                 blk_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned IdxW = $clog2(MAX_OUTSTANDING);
  localparam logic [IdxW:0] OccMax = (IdxW + 1)'(MAX_OUTSTANDING);

  t_rd_eng_state        state_q, state_d;
  logic [CL_ADDR_W-1:0] addr_q, addr_d;
  logic [26:0]          n_q, n_d;
  logic [26:0]          issue_cnt_q, issue_cnt_d;
  logic [26:0]          deliv_cnt_q, deliv_cnt_d;
  logic [IdxW-1:0]      issue_ptr_q, issue_ptr_d;
  logic [IdxW-1:0]      head_ptr_q, head_ptr_d;
  logic [IdxW:0]        occ_q, occ_d;
  logic                 err_q, err_d;

  logic            issue, pop, head_valid, tag_pending, rsp_ok, rsp_bad;
  logic [IdxW-1:0] rsp_idx;
  logic [26:0]     start_lines;
  logic            unused_addr;

  assign unused_addr = ^buf_addr[63:CL_ADDR_W+6];

  assign start_lines = line_count(buf_size);
  assign issue       = (state_q == S_RE_FETCH) && !c0_alm_full && (occ_q < OccMax);
  assign pop         = head_valid && blk_ready;
  assign rsp_idx     = rd_rsp_mdata[IdxW-1:0];
  // Tags with bits above the slot index can never have been issued.
  assign rsp_ok      = rd_rsp_valid && ((rd_rsp_mdata >> IdxW) == '0) && tag_pending;
  assign rsp_bad     = rd_rsp_valid && !rsp_ok;

  rs_dec_rob #(
    .Depth (MAX_OUTSTANDING),
    .IdxW  (IdxW)
  ) u_rob (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .alloc_i       (issue),
    .alloc_idx_i   (issue_ptr_q),
    .wr_i          (rsp_ok),
    .wr_idx_i      (rsp_idx),
    .wr_data_i     (rd_rsp_data),
    .pop_i         (pop),
    .head_idx_i    (head_ptr_q),
    .tag_pending_o (tag_pending),
    .head_valid_o  (head_valid),
    .head_data_o   (blk_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    n_d         = n_q;
    issue_cnt_d = issue_cnt_q;
    deliv_cnt_d = deliv_cnt_q;
    issue_ptr_d = issue_ptr_q;
    head_ptr_d  = head_ptr_q;
    occ_d       = occ_q;
    err_d       = err_q;

    if (pop) begin
      head_ptr_d  = head_ptr_q + 1'b1;
      deliv_cnt_d = deliv_cnt_q + 27'd1;
    end
    if (issue && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!issue && pop) begin
      occ_d = occ_q - 1'b1;
    end

    unique case (state_q)
      S_RE_IDLE: begin
        if (start) begin
          // The ROB is empty here, so both pointers restart at slot 0.
          err_d       = 1'b0;
          n_d         = start_lines;
          addr_d      = buf_addr[CL_ADDR_W+5:6];
          issue_cnt_d = '0;
          deliv_cnt_d = '0;
          issue_ptr_d = '0;
          head_ptr_d  = '0;
          if (buf_addr[5:0] != 6'd0) begin
            err_d   = 1'b1;
            state_d = S_RE_FINISH;
          end else if (start_lines == 27'd0) begin
            state_d = S_RE_FINISH;
          end else begin
            state_d = S_RE_FETCH;
          end
        end
      end
      S_RE_FETCH: begin
        if (issue) begin
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q + 27'd1;
          issue_ptr_d = issue_ptr_q + 1'b1;
          if (issue_cnt_q == n_q - 27'd1) begin
            state_d = S_RE_DRAIN;
          end
        end
      end
      S_RE_DRAIN: begin
        if (deliv_cnt_q == n_q) begin
          state_d = S_RE_FINISH;
        end
      end
      S_RE_FINISH: state_d = S_RE_IDLE;
      default:     state_d = S_RE_IDLE;
    endcase

    if (rsp_bad) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RE_IDLE;
      addr_q      <= '0;
      n_q         <= '0;
      issue_cnt_q <= '0;
      deliv_cnt_q <= '0;
      issue_ptr_q <= '0;
      head_ptr_q  <= '0;
      occ_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      issue_cnt_q <= issue_cnt_d;
      deliv_cnt_q <= deliv_cnt_d;
      issue_ptr_q <= issue_ptr_d;
      head_ptr_q  <= head_ptr_d;
      occ_q       <= occ_d;
      err_q       <= err_d;
    end
  end

  assign rd_req_valid = issue;
  assign rd_req_addr  = issue ? addr_q : '0;
  assign rd_req_mdata = issue ? MDATA_W'(issue_ptr_q) : '0;
  assign blk_valid    = head_valid;
  assign busy         = (state_q != S_RE_IDLE);
  assign done         = (state_q == S_RE_FINISH);
  assign err          = err_q;

endmodule
